ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: the transmit direction of the PS/2 port read by `keyboard_tracker`. It sends one command byte, e.g. 0xED (set LEDs) or 0xF4 (enable reporting), to the keyboard or mouse. It runs the full host-request sequence on the shared open-collector `PS2_CLK`/`PS2_DAT` lines, including inhibit, request-to-send, device-clocked shifting, parity, stop and acknowledge. It sits beside the receiver in `main`, and the top level owns the tristate buffers.

---
 rtl/ps2_host_tx_pkg.sv | 33 +++
 rtl/ps2_host_tx_if.sv | 27 ++
 rtl/ps2_line_filter.sv | 64 ++++++
 rtl/ps2_host_tx.sv | 191 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_host_tx_pkg.sv
// ps2_defs: shared definitions for the PS/2 host transmitter and receiver.
//   - ps2_state_e : transmitter FSM states
//   - ERR_*       : err_code values reported on an aborted transfer
//   - PS2_*       : default timing constants for a 50 MHz system clock
//   - odd_parity  : PS/2 frame parity bit for a data byte
package ps2_defs;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_WAIT_START,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_state_e;

  localparam logic [1:0] ERR_NONE           = 2'b00;
  localparam logic [1:0] ERR_START_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_PACKET_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_NO_ACK         = 2'b11;

  localparam int unsigned PS2_INHIBIT_CYCLES = 6000;    // 120 us
  localparam int unsigned PS2_START_TIMEOUT  = 750000;  // 15 ms
  localparam int unsigned PS2_PACKET_TIMEOUT = 100000;  // 2 ms
  localparam int unsigned PS2_FILTER_DEPTH   = 8;

  // Parity bit that makes the total number of ones in data+parity odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake plus open-collector line controls of the
// PS/2 host transmitter.
//   master : the transmitter (takes send/data_in and raw line levels,
//            drives status and the two output enables)
//   slave  : the user / board side (drives send, data_in, line levels)
interface ps2_host_tx_if;
  logic       send;
  logic [7:0] data_in;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] err_code;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       ps2_clk_in;
  logic       ps2_dat_in;

  modport master (
    input  send, data_in, ps2_clk_in, ps2_dat_in,
    output busy, done, error, err_code, ps2_clk_oe, ps2_dat_oe
  );

  modport slave (
    output send, data_in, ps2_clk_in, ps2_dat_in,
    input  busy, done, error, err_code, ps2_clk_oe, ps2_dat_oe
  );
endinterface

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: deglitcher for a slow open-collector PS/2 line.
//   clk, rst_n : system clock, asynchronous active-low reset
//   line_in    : raw asynchronous line level
//   level      : filtered level; changes only after FILTER_DEPTH consecutive
//                synchronised samples of the new value
//   fall       : one-cycle strobe, high in the cycle level goes 1 -> 0
module ps2_line_filter
  import ps2_defs::*;
#(
  parameter int unsigned FILTER_DEPTH = PS2_FILTER_DEPTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic level,
  output logic fall
);

  localparam int unsigned CW = $clog2(FILTER_DEPTH + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          fall_q,  fall_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d = line_in;
    sync2_d = sync1_q;
    level_d = level_q;
    fall_d  = 1'b0;
    cnt_d   = '0;
    // Any sample agreeing with the current level restarts the run count.
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(FILTER_DEPTH - 1)) begin
        level_d = sync2_q;
        fall_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Idle PS/2 lines float high, so the synchroniser resets to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter. Sends one command byte using
// the inhibit / request-to-send / device-clocked sequence and checks the ack.
//   clock, reset_n : system clock, asynchronous active-low reset
//   bus (master)   : send/data_in request, busy/done/error/err_code status,
//                    ps2_clk_oe/ps2_dat_oe (1 = pull line low), raw line inputs
module ps2_host_tx
  import ps2_defs::*;
#(
  parameter int unsigned INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int unsigned START_TIMEOUT  = PS2_START_TIMEOUT,
  parameter int unsigned PACKET_TIMEOUT = PS2_PACKET_TIMEOUT,
  parameter int unsigned FILTER_DEPTH   = PS2_FILTER_DEPTH
) (
  input logic          clock,
  input logic          reset_n,
  ps2_host_tx_if.master bus
);

  localparam int unsigned MAX_A = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
  localparam int unsigned MAX_T = (MAX_A > PACKET_TIMEOUT) ? MAX_A : PACKET_TIMEOUT;
  localparam int unsigned TW    = $clog2(MAX_T + 1);

  ps2_state_e state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;   // per-state timer, cleared on every state entry
  logic [TW-1:0] pkt_q, pkt_d;   // packet timer, first falling edge .. WAIT_IDLE
  logic [3:0]    n_q, n_d;       // filtered falling edges seen in this frame
  logic [7:0]    data_q, data_d;
  logic          par_q, par_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [1:0]    err_q, err_d;
  logic          clk_oe_q, clk_oe_d;
  logic          dat_oe_q, dat_oe_d;
  logic          dat_s1_q, dat_s1_d;
  logic          dat_s2_q, dat_s2_d;

  logic clk_level;
  logic clk_fall;

  ps2_line_filter #(
    .FILTER_DEPTH(FILTER_DEPTH)
  ) u_clk_filter (
    .clk    (clock),
    .rst_n  (reset_n),
    .line_in(bus.ps2_clk_in),
    .level  (clk_level),
    .fall   (clk_fall)
  );

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q + 1'b1;
    pkt_d    = '0;
    n_d      = n_q;
    data_d   = data_q;
    par_d    = par_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
    err_d    = err_q;
    dat_s1_d = bus.ps2_dat_in;
    dat_s2_d = dat_s1_q;

    unique case (state_q)
      ST_IDLE: begin
        n_d = '0;
        if (bus.send) begin
          data_d  = bus.data_in;
          par_d   = odd_parity(bus.data_in);
          err_d   = ERR_NONE;
          state_d = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (tmr_q == TW'(INHIBIT_CYCLES - 1)) state_d = ST_REQ;
      end
      ST_REQ: begin
        state_d = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (clk_fall) begin
          n_d     = 4'd1;
          state_d = ST_SHIFT;
        end else if (tmr_q == TW'(START_TIMEOUT - 1)) begin
          error_d = 1'b1;
          err_d   = ERR_START_TIMEOUT;
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        pkt_d = pkt_q + 1'b1;
        if (clk_fall) begin
          n_d = n_q + 4'd1;
          if (n_q == 4'd9) state_d = ST_ACK;
        end else if (pkt_q == TW'(PACKET_TIMEOUT - 1)) begin
          error_d = 1'b1;
          err_d   = ERR_PACKET_TIMEOUT;
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        pkt_d = pkt_q + 1'b1;
        if (clk_fall) begin
          if (!dat_s2_q) begin
            state_d = ST_WAIT_IDLE;
          end else begin
            error_d = 1'b1;
            err_d   = ERR_NO_ACK;
            state_d = ST_IDLE;
          end
        end else if (pkt_q == TW'(PACKET_TIMEOUT - 1)) begin
          error_d = 1'b1;
          err_d   = ERR_PACKET_TIMEOUT;
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        pkt_d = pkt_q + 1'b1;
        if (clk_level) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (pkt_q == TW'(PACKET_TIMEOUT - 1)) begin
          error_d = 1'b1;
          err_d   = ERR_PACKET_TIMEOUT;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d != state_q || state_q == ST_IDLE) tmr_d = '0;

    // Line drives are registered from the next state, so every abort releases
    // both lines in the same cycle that error rises.
    busy_d   = (state_d != ST_IDLE);
    clk_oe_d = (state_d == ST_INHIBIT) || (state_d == ST_REQ);
    dat_oe_d = 1'b0;
    unique case (state_d)
      ST_REQ, ST_WAIT_START: dat_oe_d = 1'b1;
      ST_SHIFT: begin
        if (n_d >= 4'd1 && n_d <= 4'd8) dat_oe_d = ~data_d[3'(n_d - 4'd1)];
        else if (n_d == 4'd9)           dat_oe_d = ~par_d;
      end
      default: dat_oe_d = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      tmr_q    <= '0;
      pkt_q    <= '0;
      n_q      <= '0;
      data_q   <= '0;
      par_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      err_q    <= ERR_NONE;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      pkt_q    <= pkt_d;
      n_q      <= n_d;
      data_q   <= data_d;
      par_q    <= par_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      err_q    <= err_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      dat_s1_q <= dat_s1_d;
      dat_s2_q <= dat_s2_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.err_code   = err_q;
  assign bus.ps2_clk_oe = clk_oe_q;
  assign bus.ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: self-checking bench for ps2_host_tx with a behavioural PS/2
// device model; timing parameters are scaled down to keep runs short.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int unsigned INH      = 40;
  localparam int unsigned START_TO = 1500;
  localparam int unsigned PKT_TO   = 2500;
  localparam int unsigned FD       = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  logic glitch_low  = 1'b0;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  int unsigned done_seen = 0, err_seen = 0, both_seen = 0, long_seen = 0;
  int unsigned oe_err_seen = 0, clk_oe_cycles = 0;
  logic prev_done = 1'b0, prev_err = 1'b0;

  ps2_host_tx_if bus();

  // Open-collector wired-AND of host and device pull-downs.
  assign bus.ps2_clk_in = ~(bus.ps2_clk_oe | dev_clk_low | glitch_low);
  assign bus.ps2_dat_in = ~(bus.ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT (START_TO),
    .PACKET_TIMEOUT(PKT_TO),
    .FILTER_DEPTH  (FD)
  ) dut (
    .clock  (clk),
    .reset_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_seen <= done_seen + 1;
    if (bus.error === 1'b1) err_seen <= err_seen + 1;
    if (bus.done === 1'b1 && bus.error === 1'b1) both_seen <= both_seen + 1;
    if ((bus.done === 1'b1 && prev_done === 1'b1) || (bus.error === 1'b1 && prev_err === 1'b1))
      long_seen <= long_seen + 1;
    if (bus.error === 1'b1 && (bus.ps2_clk_oe !== 1'b0 || bus.ps2_dat_oe !== 1'b0))
      oe_err_seen <= oe_err_seen + 1;
    if (bus.ps2_clk_oe === 1'b1) clk_oe_cycles <= clk_oe_cycles + 1;
    prev_done <= bus.done;
    prev_err  <= bus.error;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected on-wire frame: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] ref_frame(input logic [7:0] b);
    int unsigned ones = 0;
    for (int unsigned i = 0; i < 8; i++) if (b[i]) ones++;
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b, 1'b0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Device: waits for request-to-send, then clocks the frame in, sampling the
  // data line at the end of each low phase. Can stop early holding clock low.
  task automatic dev_xfer(input int unsigned hp, input int unsigned n_edges,
                          input bit do_ack, input bit glitch,
                          output logic [10:0] bits, output bit ok);
    int unsigned n = 0;
    bits = '1;
    ok   = 1'b0;
    while (!(bus.ps2_clk_oe === 1'b0 && bus.ps2_dat_oe === 1'b1) && n < INH + 100) begin
      step();
      n++;
    end
    if (n >= INH + 100) return;
    ok = 1'b1;
    repeat (hp) step();
    bits[0] = bus.ps2_dat_in;
    for (int unsigned i = 1; i <= n_edges; i++) begin
      dev_clk_low = 1'b1;
      if (i == 11 && do_ack) dev_dat_low = 1'b1;
      repeat (hp) step();
      if (i <= 10) bits[i] = bus.ps2_dat_in;
      if (i == n_edges && n_edges < 11) return;
      dev_clk_low = 1'b0;
      if (glitch && i == 4) begin
        repeat (hp / 2) step();
        glitch_low = 1'b1;
        repeat (3) step();
        glitch_low = 1'b0;
        repeat (hp - hp / 2 - 3) step();
      end else begin
        repeat (hp) step();
      end
      dev_dat_low = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.error !== 1'b0) begin n_bad++; $display("FAIL reset_error: got %b want 0", bus.error); end
    n_cmp++; if (bus.err_code !== 2'b00) begin n_bad++; $display("FAIL reset_err_code: got %b want 00", bus.err_code); end
    n_cmp++; if (bus.ps2_clk_oe !== 1'b0) begin n_bad++; $display("FAIL reset_clk_oe: got %b want 0", bus.ps2_clk_oe); end
    n_cmp++; if (bus.ps2_dat_oe !== 1'b0) begin n_bad++; $display("FAIL reset_dat_oe: got %b want 0", bus.ps2_dat_oe); end
    rst_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_transfer(input logic [7:0] b, input int unsigned hp,
                               input bit glitch, input bit check_timing);
    logic [10:0] bits;
    logic [10:0] exp;
    bit ok;
    int unsigned d0, e0, c0, n;
    exp = ref_frame(b);
    d0 = done_seen; e0 = err_seen; c0 = clk_oe_cycles;
    bus.data_in = b;
    bus.send    = 1'b1;
    step();
    bus.send    = 1'b0;
    if (check_timing) begin
      n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL xfer_busy_rise: got %b want 1", bus.busy); end
      n_cmp++; if (bus.ps2_clk_oe !== 1'b1) begin n_bad++; $display("FAIL xfer_clk_oe_rise: got %b want 1", bus.ps2_clk_oe); end
      n = 0;
      while (bus.ps2_dat_oe !== 1'b1 && n < INH + 20) begin step(); n++; end
      n_cmp++; if (n != INH) begin n_bad++; $display("FAIL xfer_dat_oe_delay: got %0d want %0d", n, INH); end
    end
    dev_xfer(hp, 11, 1'b1, glitch, bits, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL xfer_rts_seen: got %b want 1", ok); end
    n_cmp++; if (bits !== exp) begin n_bad++; $display("FAIL xfer_frame byte %h: got %b want %b", b, bits, exp); end
    n = 0;
    while (bus.busy !== 1'b0 && n < 500) begin step(); n++; end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL xfer_busy_drop: got %b want 0", bus.busy); end
    n_cmp++; if (done_seen - d0 != 1) begin n_bad++; $display("FAIL xfer_done_count: got %0d want 1", done_seen - d0); end
    n_cmp++; if (err_seen - e0 != 0) begin n_bad++; $display("FAIL xfer_error_count: got %0d want 0", err_seen - e0); end
    n_cmp++; if (bus.err_code !== 2'b00) begin n_bad++; $display("FAIL xfer_err_code: got %b want 00", bus.err_code); end
    n_cmp++; if (clk_oe_cycles - c0 != INH + 1) begin n_bad++; $display("FAIL xfer_clk_oe_cycles: got %0d want %0d", clk_oe_cycles - c0, INH + 1); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      test_transfer(8'($urandom_range(0, 255)), $urandom_range(30, 60), 1'b0, 1'b0);
    end
  endtask

  task automatic test_start_timeout();
    int unsigned d0, e0, n;
    d0 = done_seen; e0 = err_seen;
    bus.data_in = 8'($urandom);
    bus.send    = 1'b1;
    step();
    bus.send    = 1'b0;
    n = 0;
    while (!(bus.ps2_clk_oe === 1'b0 && bus.ps2_dat_oe === 1'b1) && n < INH + 20) begin step(); n++; end
    n_cmp++; if (n >= INH + 20) begin n_bad++; $display("FAIL sto_release: got timeout want clock release"); end
    n = 0;
    while (bus.error !== 1'b1 && n < START_TO + 50) begin step(); n++; end
    n_cmp++; if (n != START_TO) begin n_bad++; $display("FAIL sto_delay: got %0d want %0d", n, START_TO); end
    n_cmp++; if (bus.err_code !== 2'b01) begin n_bad++; $display("FAIL sto_err_code: got %b want 01", bus.err_code); end
    n_cmp++; if (bus.ps2_clk_oe !== 1'b0 || bus.ps2_dat_oe !== 1'b0) begin n_bad++; $display("FAIL sto_oe: got %b%b want 00", bus.ps2_clk_oe, bus.ps2_dat_oe); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL sto_busy: got %b want 0", bus.busy); end
    step();
    n_cmp++; if (bus.error !== 1'b0) begin n_bad++; $display("FAIL sto_error_width: got %b want 0", bus.error); end
    n_cmp++; if (done_seen - d0 != 0 || err_seen - e0 != 1) begin n_bad++; $display("FAIL sto_counts: got done %0d err %0d want 0 1", done_seen - d0, err_seen - e0); end
  endtask

  task automatic test_no_ack();
    logic [10:0] bits;
    logic [7:0] b;
    bit ok;
    int unsigned d0, e0, n;
    b = 8'($urandom);
    d0 = done_seen; e0 = err_seen;
    n_cmp++; if (bus.err_code !== 2'b01) begin n_bad++; $display("FAIL nack_err_held: got %b want 01", bus.err_code); end
    bus.data_in = b;
    bus.send    = 1'b1;
    step();
    bus.send    = 1'b0;
    n_cmp++; if (bus.err_code !== 2'b00) begin n_bad++; $display("FAIL nack_err_cleared: got %b want 00", bus.err_code); end
    dev_xfer(45, 11, 1'b0, 1'b0, bits, ok);
    n_cmp++; if (bits !== ref_frame(b) || ok !== 1'b1) begin n_bad++; $display("FAIL nack_frame: got %b want %b", bits, ref_frame(b)); end
    n = 0;
    while (bus.busy !== 1'b0 && n < 500) begin step(); n++; end
    n_cmp++; if (err_seen - e0 != 1) begin n_bad++; $display("FAIL nack_error_count: got %0d want 1", err_seen - e0); end
    n_cmp++; if (bus.err_code !== 2'b11) begin n_bad++; $display("FAIL nack_err_code: got %b want 11", bus.err_code); end
    n_cmp++; if (done_seen - d0 != 0) begin n_bad++; $display("FAIL nack_done_count: got %0d want 0", done_seen - d0); end
  endtask

  task automatic test_reset_mid();
    logic [10:0] bits;
    bit ok;
    int unsigned d0, e0;
    d0 = done_seen; e0 = err_seen;
    bus.data_in = 8'h00;  // d3 = 0, so the data line is held low after edge 4
    bus.send    = 1'b1;
    step();
    bus.send    = 1'b0;
    dev_xfer(40, 4, 1'b0, 1'b0, bits, ok);
    n_cmp++; if (bus.ps2_dat_oe !== 1'b1 || bus.busy !== 1'b1) begin n_bad++; $display("FAIL rmid_pre: got dat_oe %b busy %b want 1 1", bus.ps2_dat_oe, bus.busy); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.ps2_clk_oe !== 1'b0 || bus.ps2_dat_oe !== 1'b0) begin n_bad++; $display("FAIL rmid_oe: got %b%b want 00", bus.ps2_clk_oe, bus.ps2_dat_oe); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", bus.busy); end
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    repeat (5) step();
    rst_n = 1'b1;
    repeat (20) step();
    n_cmp++; if (done_seen - d0 != 0 || err_seen - e0 != 0) begin n_bad++; $display("FAIL rmid_no_pulse: got done %0d err %0d want 0 0", done_seen - d0, err_seen - e0); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] bits;
    logic [7:0] b1, b2;
    bit ok;
    int unsigned d0, n;
    b1 = 8'($urandom);
    b2 = ~b1;
    d0 = done_seen;
    bus.data_in = b1;
    bus.send    = 1'b1;
    step();
    bus.data_in = b2;
    step();
    bus.send    = 1'b0;
    dev_xfer(50, 11, 1'b1, 1'b0, bits, ok);
    n_cmp++; if (bits !== ref_frame(b1)) begin n_bad++; $display("FAIL b2b_frame: got %b want %b", bits, ref_frame(b1)); end
    n = 0;
    while (bus.busy !== 1'b0 && n < 500) begin step(); n++; end
    repeat (100) step();
    n_cmp++; if (done_seen - d0 != 1) begin n_bad++; $display("FAIL b2b_done_count: got %0d want 1", done_seen - d0); end
    n_cmp++; if (bus.busy !== 1'b0 || bus.ps2_clk_oe !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: got busy %b clk_oe %b want 0 0", bus.busy, bus.ps2_clk_oe); end
  endtask

  task automatic test_pulse_rules();
    n_cmp++; if (both_seen != 0) begin n_bad++; $display("FAIL done_error_overlap: got %0d want 0", both_seen); end
    n_cmp++; if (long_seen != 0) begin n_bad++; $display("FAIL pulse_width: got %0d long pulses want 0", long_seen); end
    n_cmp++; if (oe_err_seen != 0) begin n_bad++; $display("FAIL error_oe_release: got %0d want 0", oe_err_seen); end
  endtask

  initial begin
    bus.send    = 1'b0;
    bus.data_in = 8'h00;
    test_reset();
    test_transfer(8'hF4, 40, 1'b0, 1'b1);
    test_transfer(8'hED, 40, 1'b0, 1'b1);
    test_random();
    test_start_timeout();
    test_no_ack();
    test_reset_mid();
    test_transfer(8'h55, 45, 1'b0, 1'b1);
    test_back_to_back();
    test_transfer(8'($urandom), $urandom_range(30, 60), 1'b1, 1'b0);
    test_pulse_rules();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
